// File: rtl/credit_change_ctrl_if.sv
// credit_change_ctrl_if
// Groups the event inputs, credit feedback, vend pulses and the change
// dispenser handshake of credit_change_ctrl.
//   slave  : the controller side (credit_change_ctrl)
//   master : the environment side (next-state logic, user events, dispenser)
// Signals:
//   EVT_VALID, PRODUCT[1:0], COIN[1:0] : user event strobe and payload
//   NEXT[3:0]    : next credit computed by the next-state logic
//   CURRENT[3:0] : registered credit fed back to the next-state logic
//   VEND_15, VEND_40 : one-cycle vend pulses
//   CHG_REQ, CHG_COIN[1:0], CHG_ACK : four-phase change-coin handshake
//   BUSY, EVT_DROP : controller busy flag and dropped-event pulse
interface credit_change_ctrl_if;
  logic       EVT_VALID;
  logic [1:0] PRODUCT;
  logic [1:0] COIN;
  logic [3:0] NEXT;
  logic       CHG_ACK;
  logic [3:0] CURRENT;
  logic       VEND_15;
  logic       VEND_40;
  logic       CHG_REQ;
  logic [1:0] CHG_COIN;
  logic       BUSY;
  logic       EVT_DROP;

  modport slave (
    input  EVT_VALID, PRODUCT, COIN, NEXT, CHG_ACK,
    output CURRENT, VEND_15, VEND_40, CHG_REQ, CHG_COIN, BUSY, EVT_DROP
  );

  modport master (
    output EVT_VALID, PRODUCT, COIN, NEXT, CHG_ACK,
    input  CURRENT, VEND_15, VEND_40, CHG_REQ, CHG_COIN, BUSY, EVT_DROP
  );
endinterface

// File: rtl/credit_change_ctrl.sv
// credit_change_ctrl
// Credit register stage of the vending machine. Loads NEXT on accepted user
// events (bounded by CREDIT_MAX), flags vends, and on a return-change request
// pays the captured credit out greedily (25c/10c/5c) over a four-phase
// handshake with the change dispenser. Credit is in 5-cent units.
// Ports:
//   CLK    : system clock, rising edge
//   RESETN : asynchronous active-low reset
//   bus    : credit_change_ctrl_if.slave (events, credit, vend, change handshake)
// All outputs are registered.
module credit_change_ctrl #(
  parameter logic [3:0] CREDIT_MAX = 4'hC
) (
  input logic                  CLK,
  input logic                  RESETN,
  credit_change_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] cur_q;
  logic [3:0] rem_q;
  logic       vend15_q;
  logic       vend40_q;
  logic       req_q;
  logic [1:0] coin_q;
  logic       busy_q;
  logic       drop_q;

  // Greedy coin choice; never exceeds the amount it is given (for v != 0).
  function automatic logic [1:0] pick_coin(input logic [3:0] v);
    if (v >= 4'd5)      return 2'b11;
    else if (v >= 4'd2) return 2'b10;
    else                return 2'b01;
  endfunction

  function automatic logic [3:0] coin_units(input logic [1:0] c);
    case (c)
      2'b11:   return 4'd5;
      2'b10:   return 4'd2;
      2'b01:   return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      rem_q    <= '0;
      vend15_q <= 1'b0;
      vend40_q <= 1'b0;
      req_q    <= 1'b0;
      coin_q   <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      vend15_q <= 1'b0;
      vend40_q <= 1'b0;
      drop_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.EVT_VALID) begin
            if (bus.PRODUCT == 2'b11) begin
              cur_q <= '0;
              rem_q <= cur_q;
              // CHG_COIN is chosen on entry so it is stable for the whole request.
              if (cur_q != '0) begin
                state_q <= DISPENSE;
                busy_q  <= 1'b1;
                req_q   <= 1'b1;
                coin_q  <= pick_coin(cur_q);
              end
            end else begin
              if (bus.NEXT <= CREDIT_MAX) cur_q <= bus.NEXT;
              // Vend decision is made on the credit held before this event.
              vend15_q <= (bus.PRODUCT == 2'b01) && (cur_q >= 4'h3);
              vend40_q <= (bus.PRODUCT == 2'b10) && (cur_q >= 4'h8);
            end
          end
        end
        DISPENSE: begin
          drop_q <= bus.EVT_VALID;
          if (bus.CHG_ACK) begin
            rem_q   <= rem_q - coin_units(coin_q);
            req_q   <= 1'b0;
            coin_q  <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          drop_q <= bus.EVT_VALID;
          if (!bus.CHG_ACK) begin
            if (rem_q != '0) begin
              state_q <= DISPENSE;
              req_q   <= 1'b1;
              coin_q  <= pick_coin(rem_q);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          coin_q  <= '0;
        end
      endcase
    end
  end

  assign bus.CURRENT  = cur_q;
  assign bus.VEND_15  = vend15_q;
  assign bus.VEND_40  = vend40_q;
  assign bus.CHG_REQ  = req_q;
  assign bus.CHG_COIN = coin_q;
  assign bus.BUSY     = busy_q;
  assign bus.EVT_DROP = drop_q;

endmodule

// File: tb/tb_credit_change_ctrl.sv
// tb_credit_change_ctrl
// Directed self-checking bench for credit_change_ctrl: credit accumulation and
// ceiling, vend accept/reject, greedy change payout, long ACK, dropped events,
// zero return and asynchronous reset mid-dispense.
module tb_credit_change_ctrl;

  logic clk;
  logic rst_n;
  int   nerr;
  int   nchk;

  credit_change_ctrl_if bus ();

  credit_change_ctrl #(.CREDIT_MAX(4'hC)) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-state logic, used to drive NEXT for ordinary coin events.
  function automatic logic [3:0] model_next(input logic [1:0] p, input logic [1:0] c,
                                            input logic [3:0] cur);
    logic [4:0] s;
    s = {1'b0, cur};
    case (c)
      2'b01:   s = s + 5'd1;
      2'b10:   s = s + 5'd2;
      2'b11:   s = s + 5'd5;
      default: s = s;
    endcase
    if (p == 2'b01 && cur >= 4'd3) s = s - 5'd3;
    if (p == 2'b10 && cur >= 4'd8) s = s - 5'd8;
    if (s > 5'd15) s = 5'd15;
    return s[3:0];
  endfunction

  function automatic logic [15:0] all_outs();
    return {5'b0, bus.CURRENT, bus.VEND_15, bus.VEND_40, bus.CHG_REQ,
            bus.CHG_COIN, bus.BUSY, bus.EVT_DROP};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle event strobe; afterwards NEXT is parked on a non-zero value so
  // that holding while EVT_VALID is low is exercised too.
  task automatic evt(input logic [1:0] p, input logic [1:0] c, input logic [3:0] n);
    bus.EVT_VALID = 1'b1;
    bus.PRODUCT   = p;
    bus.COIN      = c;
    bus.NEXT      = n;
    tick();
    bus.EVT_VALID = 1'b0;
    bus.PRODUCT   = 2'b00;
    bus.COIN      = 2'b00;
    bus.NEXT      = 4'h9;
  endtask

  // Single-cycle ACK; returns with the bench just past the edge that saw ACK low.
  task automatic ack_pulse(input string tag);
    bus.CHG_ACK = 1'b1;
    tick();
    chk({tag, "_req_low"}, {15'b0, bus.CHG_REQ}, 16'h0);
    chk({tag, "_coin_zero"}, {14'b0, bus.CHG_COIN}, 16'h0);
    bus.CHG_ACK = 1'b0;
    tick();
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    rst_n         = 1'b0;
    bus.EVT_VALID = 1'b0;
    bus.PRODUCT   = 2'b00;
    bus.COIN      = 2'b00;
    bus.NEXT      = 4'h0;
    bus.CHG_ACK   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_outs", all_outs(), 16'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", {12'b0, bus.CURRENT}, 16'h0);

    // Coin accumulation: 25c, 25c, 10c -> 5, A, C
    evt(2'b00, 2'b11, model_next(2'b00, 2'b11, 4'h0));
    chk("acc_5", {12'b0, bus.CURRENT}, 16'h5);
    evt(2'b00, 2'b11, model_next(2'b00, 2'b11, 4'h5));
    chk("acc_A", {12'b0, bus.CURRENT}, 16'hA);
    evt(2'b00, 2'b10, model_next(2'b00, 2'b10, 4'hA));
    chk("acc_C", {12'b0, bus.CURRENT}, 16'hC);
    tick();
    chk("hold_no_evt", {12'b0, bus.CURRENT}, 16'hC);

    // Ceiling
    evt(2'b00, 2'b01, 4'hC);
    chk("ceil_next_C", {12'b0, bus.CURRENT}, 16'hC);
    evt(2'b00, 2'b01, 4'hD);
    chk("ceil_next_D", {12'b0, bus.CURRENT}, 16'hC);
    evt(2'b00, 2'b01, 4'hF);
    chk("ceil_next_F", {12'b0, bus.CURRENT}, 16'hC);

    // Full change from C: coins 11, 11, 10
    evt(2'b11, 2'b00, 4'h0);
    chk("ret_cur0", {12'b0, bus.CURRENT}, 16'h0);
    chk("ret_busy", {15'b0, bus.BUSY}, 16'h1);
    chk("ret_req", {15'b0, bus.CHG_REQ}, 16'h1);
    chk("chg1_coin", {14'b0, bus.CHG_COIN}, 16'h3);
    tick();
    chk("chg1_coin_stable", {14'b0, bus.CHG_COIN}, 16'h3);
    ack_pulse("chg1");
    chk("chg2_req", {15'b0, bus.CHG_REQ}, 16'h1);
    chk("chg2_coin", {14'b0, bus.CHG_COIN}, 16'h3);

    // Event mid-dispense is dropped
    evt(2'b00, 2'b11, 4'h5);
    chk("drop_pulse", {15'b0, bus.EVT_DROP}, 16'h1);
    chk("drop_cur", {12'b0, bus.CURRENT}, 16'h0);
    chk("drop_coin", {14'b0, bus.CHG_COIN}, 16'h3);
    tick();
    chk("drop_one_cycle", {15'b0, bus.EVT_DROP}, 16'h0);

    // ACK held for 5 cycles: one decrement, no re-request
    bus.CHG_ACK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("longack_req", {15'b0, bus.CHG_REQ}, 16'h0);
      chk("longack_busy", {15'b0, bus.BUSY}, 16'h1);
    end
    bus.CHG_ACK = 1'b0;
    tick();
    chk("chg3_req", {15'b0, bus.CHG_REQ}, 16'h1);
    chk("chg3_coin", {14'b0, bus.CHG_COIN}, 16'h2);
    ack_pulse("chg3");
    chk("chgC_done_busy", {15'b0, bus.BUSY}, 16'h0);
    chk("chgC_done_req", {15'b0, bus.CHG_REQ}, 16'h0);

    // Back-to-back events right after BUSY falls: 0 -> 5 -> 7 -> 8
    evt(2'b00, 2'b11, model_next(2'b00, 2'b11, 4'h0));
    chk("b2b_5", {12'b0, bus.CURRENT}, 16'h5);
    evt(2'b00, 2'b10, model_next(2'b00, 2'b10, 4'h5));
    chk("b2b_7", {12'b0, bus.CURRENT}, 16'h7);
    evt(2'b00, 2'b01, model_next(2'b00, 2'b01, 4'h7));
    chk("b2b_8", {12'b0, bus.CURRENT}, 16'h8);

    // Vend 40c at exactly 8
    evt(2'b10, 2'b00, model_next(2'b10, 2'b00, 4'h8));
    chk("v40_pulse", {15'b0, bus.VEND_40}, 16'h1);
    chk("v40_no15", {15'b0, bus.VEND_15}, 16'h0);
    chk("v40_cur", {12'b0, bus.CURRENT}, 16'h0);
    tick();
    chk("v40_one_cycle", {15'b0, bus.VEND_40}, 16'h0);

    // Build 3, reject 40c, accept 15c
    evt(2'b00, 2'b01, model_next(2'b00, 2'b01, 4'h0));
    evt(2'b00, 2'b10, model_next(2'b00, 2'b10, 4'h1));
    chk("build_3", {12'b0, bus.CURRENT}, 16'h3);
    evt(2'b10, 2'b00, model_next(2'b10, 2'b00, 4'h3));
    chk("v40_reject", {15'b0, bus.VEND_40}, 16'h0);
    chk("v40_reject_cur", {12'b0, bus.CURRENT}, 16'h3);
    evt(2'b01, 2'b00, model_next(2'b01, 2'b00, 4'h3));
    chk("v15_pulse", {15'b0, bus.VEND_15}, 16'h1);
    chk("v15_cur", {12'b0, bus.CURRENT}, 16'h0);
    tick();
    chk("v15_one_cycle", {15'b0, bus.VEND_15}, 16'h0);

    // Zero return
    evt(2'b11, 2'b00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      chk("zret_req", {15'b0, bus.CHG_REQ}, 16'h0);
      chk("zret_busy", {15'b0, bus.BUSY}, 16'h0);
      tick();
    end

    // Change from 3: coins 10, 01
    evt(2'b00, 2'b01, model_next(2'b00, 2'b01, 4'h0));
    evt(2'b00, 2'b10, model_next(2'b00, 2'b10, 4'h1));
    evt(2'b11, 2'b00, 4'h0);
    chk("chg3c_req", {15'b0, bus.CHG_REQ}, 16'h1);
    chk("chg3c_coin1", {14'b0, bus.CHG_COIN}, 16'h2);
    ack_pulse("chg3c_a");
    chk("chg3c_coin2", {14'b0, bus.CHG_COIN}, 16'h1);
    chk("chg3c_busy", {15'b0, bus.BUSY}, 16'h1);
    ack_pulse("chg3c_b");
    chk("chg3c_done", {15'b0, bus.BUSY}, 16'h0);

    // Asynchronous reset mid-dispense
    evt(2'b00, 2'b11, model_next(2'b00, 2'b11, 4'h0));
    evt(2'b11, 2'b00, 4'h0);
    chk("arst_pre_req", {15'b0, bus.CHG_REQ}, 16'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", all_outs(), 16'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst_idle_busy", {15'b0, bus.BUSY}, 16'h0);
    chk("arst_idle_req", {15'b0, bus.CHG_REQ}, 16'h0);
    evt(2'b00, 2'b01, model_next(2'b00, 2'b01, 4'h0));
    chk("arst_coin", {12'b0, bus.CURRENT}, 16'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
